sensor_conditioner: RTL and testbench

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

---
 rtl/sensor_pkg.sv | 15 +
 rtl/sensor_conditioner_if.sv | 34 +++
 rtl/sensor_conditioner_avg_window.sv | 57 +++++
 rtl/sensor_conditioner.sv | 177 +++++++++++++++++
 tb/tb_sensor_conditioner.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_pkg.sv
// Shared types and helpers for the sensor conditioner.
// FSM encoding and averaging-window depth.
package sensor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALIB = 2'd1,
      DONE  = 2'd2
   } state_e;

   function automatic int win_depth(input int log2);
      return 1 << log2;
   endfunction

endpackage

// File: rtl/sensor_conditioner_if.sv
// Signal bundle around the sensor conditioner.
// master drives strobes and samples, slave returns results.
interface sensor_conditioner_if #(
   parameter int DATA_W = 16,
   parameter int NUM_CH = 3
) (
   input logic clk
);

   logic                     load_in;
   logic                     clear_in;
   logic                     bypass_avg_in;
   logic [NUM_CH*DATA_W-1:0] sample_in;
   logic [NUM_CH*DATA_W-1:0] offset_in;
   logic [NUM_CH*DATA_W-1:0] data_out;
   logic                     data_done_out;
   logic                     busy_out;
   logic                     avg_full_out;

   modport master (
      input  clk,
      output load_in, clear_in, bypass_avg_in,
      output sample_in, offset_in,
      input  data_out, data_done_out, busy_out, avg_full_out
   );

   modport slave (
      input  clk,
      input  load_in, clear_in, bypass_avg_in,
      input  sample_in, offset_in,
      output data_out, data_done_out, busy_out, avg_full_out
   );

endinterface

// File: rtl/sensor_conditioner_avg_window.sv
// One channel's circular sample buffer with running sum.
// Average is the sum shifted right, floor toward -inf.
module avg_window
   import sensor_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int AVG_LOG2 = 2
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                clr_in,
   input  logic                wr_in,
   input  logic [AVG_LOG2-1:0] ptr_in,
   input  logic [DATA_W-1:0]   din,
   output logic [DATA_W-1:0]   avg_out
);

   localparam int DEPTH = win_depth(AVG_LOG2);
   localparam int SUM_W = DATA_W + AVG_LOG2;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [SUM_W-1:0]  new_ext, old_ext;

   assign new_ext = {{AVG_LOG2{din[DATA_W-1]}}, din};
   assign old_ext = {{AVG_LOG2{mem_q[ptr_in][DATA_W-1]}},
                     mem_q[ptr_in]};

   // replace oldest entry, keep sum consistent with buffer
   always_comb begin
      mem_d = mem_q;
      sum_d = sum_q;
      if (clr_in) begin
         for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
         sum_d = '0;
      end else if (wr_in) begin
         mem_d[ptr_in] = din;
         sum_d = sum_q + new_ext - old_ext;
      end
   end

   // window storage
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         sum_q <= '0;
      end else begin
         mem_q <= mem_d;
         sum_q <= sum_d;
      end
   end

   // arithmetic shift then truncate == take the upper slice
   assign avg_out = sum_q[AVG_LOG2 +: DATA_W];

endmodule

// File: rtl/sensor_conditioner.sv
// Per-channel offset calibration with saturation and
// moving average; one channel handled per CALIB cycle.
module sensor_conditioner
   import sensor_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_CH   = 3,
   parameter int AVG_LOG2 = 2
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     load_in,
   input  logic                     clear_in,
   input  logic                     bypass_avg_in,
   input  logic [NUM_CH*DATA_W-1:0] sample_in,
   input  logic [NUM_CH*DATA_W-1:0] offset_in,
   output logic [NUM_CH*DATA_W-1:0] data_out,
   output logic                     data_done_out,
   output logic                     busy_out,
   output logic                     avg_full_out
);

   localparam int DEPTH = win_depth(AVG_LOG2);
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int VEC_W = NUM_CH * DATA_W;
   localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);
   localparam logic [AVG_LOG2:0] FILL_MAX = (AVG_LOG2 + 1)'(DEPTH);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [VEC_W-1:0]    sample_q, sample_d;
   logic [VEC_W-1:0]    offset_q, offset_d;
   logic [VEC_W-1:0]    cal_q, cal_d;
   logic [VEC_W-1:0]    data_q, data_d;
   logic                bypass_q, bypass_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic [AVG_LOG2-1:0] ptr_q, ptr_d;
   logic [AVG_LOG2:0]   fill_q, fill_d;

   logic                idle_ok, start, clr;
   logic [DATA_W-1:0]   cal_val;
   logic [DATA_W-1:0]   avg_w [NUM_CH];

   function automatic logic [DATA_W-1:0] sat_sub(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b
   );
      logic [DATA_W:0] d;
      d = {a[DATA_W-1], a} - {b[DATA_W-1], b};
      if (d[DATA_W] != d[DATA_W-1])
         sat_sub = d[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                             : {1'b0, {(DATA_W-1){1'b1}}};
      else
         sat_sub = d[DATA_W-1:0];
   endfunction

   // busy_q covers the cycle after DONE, so gate on it too
   assign idle_ok = (state_q == IDLE) && !busy_q;
   assign clr     = idle_ok && clear_in;
   assign start   = idle_ok && load_in && !clear_in;

   assign cal_val = sat_sub(sample_q[int'(idx_q)*DATA_W +: DATA_W],
                            offset_q[int'(idx_q)*DATA_W +: DATA_W]);

   genvar c;
   generate
      for (c = 0; c < NUM_CH; c++) begin : g_win
         avg_window #(
            .DATA_W  (DATA_W),
            .AVG_LOG2(AVG_LOG2)
         ) u_win (
            .clk    (clk),
            .n_rst  (n_rst),
            .clr_in (clr),
            .wr_in  ((state_q == CALIB) && (idx_q == IDX_W'(c))),
            .ptr_in (ptr_q),
            .din    (cal_val),
            .avg_out(avg_w[c])
         );
      end
   endgenerate

   // state register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = CALIB;
         CALIB:   if (idx_q == LAST_CH) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // output strobes, registered one cycle behind the state
   always_comb begin
      busy_d = (state_q != IDLE);
      done_d = (state_q == DONE);
   end

   // capture, per-channel calibration and result update
   always_comb begin
      idx_d    = idx_q;
      sample_d = sample_q;
      offset_d = offset_q;
      bypass_d = bypass_q;
      cal_d    = cal_q;
      data_d   = data_q;
      ptr_d    = ptr_q;
      fill_d   = fill_q;
      unique case (state_q)
         IDLE: begin
            idx_d = '0;
            if (start) begin
               sample_d = sample_in;
               offset_d = offset_in;
               bypass_d = bypass_avg_in;
            end
            if (clr) begin
               ptr_d  = '0;
               fill_d = '0;
            end
         end
         CALIB: begin
            cal_d[int'(idx_q)*DATA_W +: DATA_W] = cal_val;
            idx_d = idx_q + 1'b1;
         end
         DONE: begin
            for (int i = 0; i < NUM_CH; i++)
               data_d[i*DATA_W +: DATA_W] =
                  bypass_q ? cal_q[i*DATA_W +: DATA_W] : avg_w[i];
            ptr_d = ptr_q + 1'b1;
            if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
         end
         default: idx_d = '0;
      endcase
   end

   // datapath registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         idx_q    <= '0;
         sample_q <= '0;
         offset_q <= '0;
         bypass_q <= 1'b0;
         cal_q    <= '0;
         data_q   <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         ptr_q    <= '0;
         fill_q   <= '0;
      end else begin
         idx_q    <= idx_d;
         sample_q <= sample_d;
         offset_q <= offset_d;
         bypass_q <= bypass_d;
         cal_q    <= cal_d;
         data_q   <= data_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         ptr_q    <= ptr_d;
         fill_q   <= fill_d;
      end
   end

   assign data_out      = data_q;
   assign data_done_out = done_q;
   assign busy_out      = busy_q;
   assign avg_full_out  = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: vector table, corner
// sequences and random loads against a queue-based model.
module tb_sensor_conditioner;

   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   sensor_conditioner_if #(.DATA_W(16), .NUM_CH(3)) bus (.clk(clk));

   sensor_conditioner #(
      .DATA_W  (16),
      .NUM_CH  (3),
      .AVG_LOG2(2)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .load_in      (bus.load_in),
      .clear_in     (bus.clear_in),
      .bypass_avg_in(bus.bypass_avg_in),
      .sample_in    (bus.sample_in),
      .offset_in    (bus.offset_in),
      .data_out     (bus.data_out),
      .data_done_out(bus.data_done_out),
      .busy_out     (bus.busy_out),
      .avg_full_out (bus.avg_full_out)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      int v[3];
   } rec_t;

   typedef struct {
      int s[3];
      int o[3];
      bit byp;
      int e[3];
   } vec_t;

   rec_t hist[$];
   int   fill = 0;
   int   last_out[3] = '{0, 0, 0};

   task automatic check(input string name, input longint act,
                        input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int clamp16(input int x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   function automatic int floor_div4(input int x);
      if (x >= 0) return x / 4;
      return -((-x + 3) / 4);
   endfunction

   function automatic logic [47:0] pack(input int v[3]);
      logic [47:0] p;
      for (int c = 0; c < 3; c++) p[c*16 +: 16] = 16'(v[c]);
      return p;
   endfunction

   function automatic int out_ch(input int c);
      logic [15:0] w;
      w = bus.data_out[c*16 +: 16];
      return int'($signed(w));
   endfunction

   task automatic model_reset();
      hist.delete();
      fill = 0;
   endtask

   task automatic model_load(input int s[3], input int o[3],
                             input bit byp, output int exp[3]);
      rec_t r;
      int   sum;
      for (int c = 0; c < 3; c++) r.v[c] = clamp16(s[c] - o[c]);
      hist.push_back(r);
      if (hist.size() > 4) void'(hist.pop_front());
      for (int c = 0; c < 3; c++) begin
         sum = 0;
         foreach (hist[k]) sum += hist[k].v[c];
         exp[c] = byp ? r.v[c] : floor_div4(sum);
      end
      if (fill < 4) fill++;
   endtask

   task automatic do_load(input int s[3], input int o[3],
                          input bit byp, input int hold,
                          output int got[3]);
      int exp[3];
      int ndone = 0;
      int at = -1;
      int bogus[3] = '{1111, -2222, 3333};
      got = '{0, 0, 0};
      @(negedge clk);
      bus.sample_in = pack(s);
      bus.offset_in = pack(o);
      bus.bypass_avg_in = byp;
      bus.load_in = 1'b1;
      @(posedge clk);
      #1;
      if (hold > 1) begin
         bus.sample_in = pack(bogus);
         bus.bypass_avg_in = ~byp;
      end else begin
         bus.load_in = 1'b0;
      end
      model_load(s, o, byp, exp);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         bus.load_in = 1'b0;
         if (bus.data_done_out) begin
            ndone++;
            if (at < 0) at = k;
            for (int c = 0; c < 3; c++) got[c] = out_ch(c);
         end
         if (k == 1) check("busy_k1", bus.busy_out, 1);
         if (k == 4) begin
            check("busy_k4", bus.busy_out, 1);
            check("full", bus.avg_full_out, fill == 4);
         end
         if (k == 5) check("busy_k5", bus.busy_out, 0);
      end
      check("done_cycle", at, 4);
      check("done_count", ndone, 1);
      for (int c = 0; c < 3; c++) check("model_out", got[c], exp[c]);
      last_out = exp;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_data"}, bus.data_out, 0);
      check({tag, "_done"}, bus.data_done_out, 0);
      check({tag, "_busy"}, bus.busy_out, 0);
      check({tag, "_full"}, bus.avg_full_out, 0);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      bus.clear_in = 1'b1;
      @(posedge clk);
      #1;
      bus.clear_in = 1'b0;
      model_reset();
   endtask

   vec_t tbl[4];
   int   got[3];
   int   s[3], o[3];
   int   seen;

   initial begin
      bus.load_in = 1'b0;
      bus.clear_in = 1'b0;
      bus.bypass_avg_in = 1'b0;
      bus.sample_in = '0;
      bus.offset_in = '0;
      n_rst = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check_zero("rst");
      @(negedge clk);
      n_rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_zero("idle");

      tbl[0] = '{'{100, -200, 300}, '{0, 0, 0}, 1'b1,
                 '{100, -200, 300}};
      tbl[1] = '{'{-32768, 32767, 5}, '{1, -1, 7}, 1'b1,
                 '{-32768, 32767, -2}};
      tbl[2] = '{'{0, -1, -32768}, '{32767, 32767, 32767}, 1'b1,
                 '{-32767, -32768, -32768}};
      tbl[3] = '{'{32767, -32768, 1234}, '{-32768, 32767, -1234},
                 1'b1, '{32767, -32768, 2468}};
      for (int i = 0; i < 4; i++) begin
         do_load(tbl[i].s, tbl[i].o, tbl[i].byp, 1, got);
         for (int c = 0; c < 3; c++) check("vec", got[c], tbl[i].e[c]);
      end

      pulse_clear();
      check("clr_full", bus.avg_full_out, 0);
      for (int c = 0; c < 3; c++)
         check("clr_hold", out_ch(c), last_out[c]);

      for (int i = 0; i < 4; i++) begin
         do_load('{8, 0, 0}, '{0, 0, 0}, 1'b0, 1, got);
         check("avg_ch0", got[0], 2 * (i + 1));
         check("avg_full", bus.avg_full_out, i == 3);
      end
      do_load('{0, 0, 0}, '{0, 0, 0}, 1'b0, 1, got);
      check("avg_fifth", got[0], 6);

      do_load('{40, -40, 7}, '{0, 0, 0}, 1'b1, 2, got);
      check("coll_ch0", got[0], 40);
      check("coll_ch1", got[1], -40);

      @(negedge clk);
      bus.sample_in = pack('{9, 9, 9});
      bus.load_in = 1'b1;
      bus.clear_in = 1'b1;
      @(posedge clk);
      #1;
      bus.load_in = 1'b0;
      bus.clear_in = 1'b0;
      model_reset();
      seen = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (bus.busy_out || bus.data_done_out) seen++;
      end
      check("ldclr_activity", seen, 0);
      check("ldclr_full", bus.avg_full_out, 0);

      @(negedge clk);
      bus.sample_in = pack('{8, 0, 0});
      bus.offset_in = '0;
      bus.bypass_avg_in = 1'b0;
      bus.load_in = 1'b1;
      @(posedge clk);
      #1;
      bus.load_in = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      n_rst = 1'b0;
      #1;
      check_zero("midrst");
      seen = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (bus.data_done_out) seen++;
      end
      check("midrst_done", seen, 0);
      @(negedge clk);
      n_rst = 1'b1;
      model_reset();
      do_load('{8, 0, 0}, '{0, 0, 0}, 1'b0, 1, got);
      check("postrst_ch0", got[0], 2);

      pulse_clear();
      for (int n = 0; n < 40; n++) begin
         for (int c = 0; c < 3; c++) begin
            if ($urandom_range(0, 2) == 0) begin
               s[c] = int'($signed(16'($urandom)));
               o[c] = int'($signed(16'($urandom)));
            end else begin
               s[c] = int'($urandom_range(0, 2000)) - 1000;
               o[c] = int'($urandom_range(0, 100)) - 50;
            end
         end
         do_load(s, o, 1'($urandom_range(0, 1)), 1, got);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
